prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Launch controller between the top-level init/done handshake and the cirno core.
- Each rising edge of init starts the next program in round-robin order (program 1, 2, 3, then back to 1).
- Loads that program's start PC, releases the core, and waits for halt; a watchdog bounds each run.
- Reports completion on done, plus per-run cycle count and timeout status.

Parameters:
- PCW, 10, width of the instruction address / PC.
- NPROG, 3, number of programs in the rotation (2..4).
- START0, 10'd0, start PC of program 1.
- START1, 10'd256, start PC of program 2.
- START2, 10'd512, start PC of program 3.
- START3, 10'd768, start PC of program 4 (used only if NPROG=4).
- CW, 16, cycle-counter width.
- WD_LIMIT, 16'd50000, watchdog limit in RUN cycles.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- init  in  1  start request; a rising edge launches the next program.
- done  out  1  run finished; held high until the next accepted init edge.
- core_pc_load  out  1  one-cycle pulse: the core loads core_pc_val into its PC.
- core_pc_val  out  PCW  start PC for the current program.
- core_run  out  1  high while the core may execute.
- core_halt  in  1  core reached its halt instruction (level, sampled in RUN only).
- core_abort  out  1  one-cycle pulse forcing the core to stop on watchdog expiry.
- prog_idx  out  2  index of the current/last program (0..NPROG-1).
- cyc_cnt  out  CW  cycles spent in RUN for the last or current run.
- timeout  out  1  last run ended by watchdog.

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE, done=0, core_run=0, core_pc_load=0, core_abort=0, timeout=0.
  - prog_idx=NPROG-1, so the first run selects 0.
  - cyc_cnt=0, init_q=0.
- Edge detect: init_q registers init each cycle; init_rise = init & ~init_q.
  - A level held high counts as one request.
  - An init pulse one cycle wide is never missed.
- States:
  - IDLE: on init_rise -> LOAD. Before that, prog_idx advances (NPROG-1 wraps to 0), done clears, timeout clears, cyc_cnt clears.
  - LOAD (1 cycle): core_pc_load=1, core_pc_val=START[prog_idx]; -> RUN.
  - RUN: core_run=1; cyc_cnt increments each cycle, saturating at all-ones.
    - On core_halt: -> DONE.
    - Else when cyc_cnt==WD_LIMIT-1: core_abort pulses for 1 cycle, timeout<=1, -> DONE.
  - DONE: core_run=0, done=1, cyc_cnt and timeout hold.
    - On init_rise: -> LOAD with the same updates as in IDLE.
- core_pc_val is held at START[prog_idx] in all states (stable before and after the load pulse).
- Latency:
  - init_rise at cycle n gives core_pc_load in cycle n+1 and core_run high from cycle n+2.
  - core_halt sampled in cycle m gives done=1 from cycle m+1.
- Simultaneous halt and watchdog expiry in the same cycle: halt wins; timeout=0, no abort.
- init_rise during LOAD or RUN is ignored; it is not queued.
- core_halt outside RUN is ignored, including a stale halt level in LOAD.
- Reset mid-run returns everything to the reset values immediately. The next init starts program index 0.

Decomposition:
- Shared package cirno_pkg holds:
  - seq_state_t enum {IDLE, LOAD, RUN, DONE}.
  - localparam PCW.
  - Default START constants, so the assembler flow and RTL agree.
- One natural sub-module: seq_watchdog (saturating cycle counter + limit compare, with clear/enable inputs and expire output).

Test Plan:
- Reset, then init pulse at cycle 3 -> core_pc_load at cycle 4 with core_pc_val=0 and prog_idx=0; core_run from cycle 5.
- Halt after 100 RUN cycles -> done=1 the next cycle, cyc_cnt=100, timeout=0.
- Three more init pulses, each followed by a halt -> core_pc_val of 256, 512, then 0, with prog_idx wrapping 1, 2, 0.
- WD_LIMIT overridden to 20 and no halt -> core_abort pulses once after 20 RUN cycles; timeout=1, done=1, cyc_cnt=20.
- Halt and watchdog expiry in the same cycle -> timeout=0 and no core_abort.
- init held high for 10 cycles -> exactly one launch.
- Extra init pulse mid-RUN -> ignored.
- reset_n low mid-RUN -> core_run=0 at once, done=0; the next run uses program index 0.

Source files
------------

// File: rtl/cirno_pkg.sv
// Shared sequencer state type, PC width and default program start PCs,
// so the assembler flow and the RTL agree on where each program begins.
package cirno_pkg;

  localparam int unsigned PCW = 10;

  localparam logic [PCW-1:0] START_PC0 = 10'd0;
  localparam logic [PCW-1:0] START_PC1 = 10'd256;
  localparam logic [PCW-1:0] START_PC2 = 10'd512;
  localparam logic [PCW-1:0] START_PC3 = 10'd768;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Saturating run-cycle counter with limit compare; count visible one cycle after en.
// No backpressure: clr wins over en, expire is a pure compare on the current count.
module seq_watchdog #(
  parameter int unsigned     CW    = 16,
  parameter logic [CW-1:0]   LIMIT = CW'(50000)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          expire
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  // Compare against LIMIT-1 so the run stops after exactly LIMIT counted cycles.
  assign expire = (cnt_q == (LIMIT - CW'(1)));

endmodule

// File: rtl/prog_sequencer.sv
// Round-robin program launcher: init edge -> pc_load next cycle -> run until halt/watchdog.
// init edges outside IDLE/DONE are dropped, never queued; done holds until next launch.
module prog_sequencer
  import cirno_pkg::*;
#(
  parameter int unsigned   PCW      = cirno_pkg::PCW,
  parameter int unsigned   NPROG    = 3,
  parameter logic [PCW-1:0] START0  = START_PC0,
  parameter logic [PCW-1:0] START1  = START_PC1,
  parameter logic [PCW-1:0] START2  = START_PC2,
  parameter logic [PCW-1:0] START3  = START_PC3,
  parameter int unsigned   CW       = 16,
  parameter logic [CW-1:0] WD_LIMIT = CW'(50000)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           init,
  output logic           done,
  output logic           core_pc_load,
  output logic [PCW-1:0] core_pc_val,
  output logic           core_run,
  input  logic           core_halt,
  output logic           core_abort,
  output logic [1:0]     prog_idx,
  output logic [CW-1:0]  cyc_cnt,
  output logic           timeout
);

  localparam logic [1:0] LAST_IDX = 2'(NPROG - 1);

  seq_state_t    state_q, state_d;
  logic [1:0]    prog_idx_q, prog_idx_d;
  logic          timeout_q, timeout_d;
  logic          init_q;
  logic          init_rise;
  logic          accept;
  logic          wd_expire;
  logic [CW-1:0] wd_cnt;

  assign init_rise = init & ~init_q;

  seq_watchdog #(
    .CW    (CW),
    .LIMIT (WD_LIMIT)
  ) u_wd (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .en      (state_q == RUN),
    .cnt     (wd_cnt),
    .expire  (wd_expire)
  );

  always_comb begin
    state_d    = state_q;
    prog_idx_d = prog_idx_q;
    timeout_d  = timeout_q;
    accept     = 1'b0;
    core_abort = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (init_rise) begin
          accept     = 1'b1;
          state_d    = LOAD;
          timeout_d  = 1'b0;
          prog_idx_d = (prog_idx_q == LAST_IDX) ? 2'd0 : prog_idx_q + 2'd1;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        // A halt seen in the expiry cycle is a clean finish, not a timeout.
        if (core_halt) begin
          state_d = DONE;
        end else if (wd_expire) begin
          core_abort = 1'b1;
          timeout_d  = 1'b1;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_pc_val = START0;
    case (prog_idx_q)
      2'd0:    core_pc_val = START0;
      2'd1:    core_pc_val = START1;
      2'd2:    core_pc_val = START2;
      default: core_pc_val = START3;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      prog_idx_q <= LAST_IDX;
      timeout_q  <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_idx_q <= prog_idx_d;
      timeout_q  <= timeout_d;
      init_q     <= init;
    end
  end

  assign core_pc_load = (state_q == LOAD);
  assign core_run     = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign prog_idx     = prog_idx_q;
  assign timeout      = timeout_q;
  assign cyc_cnt      = wd_cnt;

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized scoreboard bench for prog_sequencer: launches queue expected
// loads/results, negedge monitors pop and compare when the DUT presents them.
module tb_prog_sequencer;
  import cirno_pkg::*;

  localparam int NPROG = 3;
  localparam int CW    = 16;
  localparam int WD    = 120;
  localparam int NEVER = 1000;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           init = 1'b0;
  logic           core_halt = 1'b0;
  logic           done, core_pc_load, core_run, core_abort, timeout;
  logic [PCW-1:0] core_pc_val;
  logic [1:0]     prog_idx;
  logic [CW-1:0]  cyc_cnt;

  prog_sequencer #(
    .NPROG    (NPROG),
    .CW       (CW),
    .WD_LIMIT (16'(WD))
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .init         (init),
    .done         (done),
    .core_pc_load (core_pc_load),
    .core_pc_val  (core_pc_val),
    .core_run     (core_run),
    .core_halt    (core_halt),
    .core_abort   (core_abort),
    .prog_idx     (prog_idx),
    .cyc_cnt      (cyc_cnt),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int pc; int cycles; bit to; } run_exp_t;
  typedef struct { int idx; int pc; int cyc; } load_exp_t;

  run_exp_t  run_q[$];
  load_exp_t load_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int halt_target = NEVER;
  int runs_since_reset = 0;
  int start_tab [4] = '{0, 256, 512, 768};

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: halts in the chosen RUN cycle, drives noise on core_halt elsewhere.
  int rc = 0;
  always @(posedge clk) begin
    #1;
    if (core_run) begin
      rc++;
      core_halt = (rc == halt_target);
    end else begin
      rc = 0;
      core_halt = 1'($urandom_range(0, 1));
    end
  end

  // Monitor / scoreboard.
  int        last_load_cyc = 0;
  int        run_start = 0;
  int        abort_cnt = 0;
  logic      prev_done = 1'b0;
  logic      prev_run = 1'b0;
  load_exp_t le;
  run_exp_t  re;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_done = 1'b0;
      prev_run  = 1'b0;
      abort_cnt = 0;
    end else begin
      if (core_pc_load) begin
        if (load_q.size() == 0) begin
          check("unexpected_load", 1, 0);
        end else begin
          le = load_q.pop_front();
          check("load_pc", int'(core_pc_val), le.pc);
          check("load_idx", int'(prog_idx), le.idx);
          check("load_latency", cyc, le.cyc + 1);
        end
        last_load_cyc = cyc;
        abort_cnt = 0;
      end
      if (core_run && !prev_run) begin
        run_start = cyc;
        check("run_latency", cyc, last_load_cyc + 1);
      end
      if (core_abort) begin
        abort_cnt++;
        check("abort_in_run", int'(core_run), 1);
      end
      if (done && !prev_done) begin
        if (run_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          re = run_q.pop_front();
          check("done_idx", int'(prog_idx), re.idx);
          check("done_pc_hold", int'(core_pc_val), re.pc);
          check("done_cyc_cnt", int'(cyc_cnt), re.cycles);
          check("done_timeout", int'(timeout), int'(re.to));
          check("abort_pulses", abort_cnt, re.to ? 1 : 0);
          check("done_latency", cyc, run_start + re.cycles);
        end
      end
      prev_done = done;
      prev_run  = core_run;
    end
  end

  task automatic launch(int target, bit hold, bit mid, bit expect_done);
    int        idx;
    int        k;
    run_exp_t  r;
    load_exp_t l;
    idx = runs_since_reset % NPROG;
    runs_since_reset++;
    halt_target = target;
    @(posedge clk);
    #1;
    init = 1'b1;
    l.idx = idx;
    l.pc  = start_tab[idx];
    l.cyc = cyc;
    load_q.push_back(l);
    if (expect_done) begin
      r.idx    = idx;
      r.pc     = start_tab[idx];
      r.cycles = (target < WD) ? target : WD;
      r.to     = (target > WD);
      run_q.push_back(r);
    end
    if (hold) repeat (10) @(posedge clk);
    else @(posedge clk);
    #1 init = 1'b0;
    if (mid) begin
      repeat (4) @(posedge clk);
      #1 init = 1'b1;
      @(posedge clk);
      #1 init = 1'b0;
    end
    if (expect_done) begin
      k = 0;
      while (!done && k < WD + 50) begin
        @(posedge clk);
        #1;
        k++;
      end
      if (!done) check("done_wait_expired", 0, 1);
      repeat ($urandom_range(1, 4)) @(posedge clk);
    end
  endtask

  task automatic reset_mid_run();
    launch(NEVER, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rst_core_run", int'(core_run), 0);
    check("rst_done", int'(done), 0);
    check("rst_cyc_cnt", int'(cyc_cnt), 0);
    check("rst_prog_idx", int'(prog_idx), NPROG - 1);
    check("rst_pc_load", int'(core_pc_load), 0);
    runs_since_reset = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int t;
    bit h;
    reset_n = 1'b0;
    init    = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("reset_done", int'(done), 0);
    check("reset_core_run", int'(core_run), 0);
    check("reset_pc_load", int'(core_pc_load), 0);
    check("reset_abort", int'(core_abort), 0);
    check("reset_timeout", int'(timeout), 0);
    check("reset_prog_idx", int'(prog_idx), NPROG - 1);
    check("reset_cyc_cnt", int'(cyc_cnt), 0);
    check("reset_pc_val", int'(core_pc_val), start_tab[NPROG - 1]);

    launch(100, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) launch($urandom_range(1, 60), 1'b0, 1'b0, 1'b1);
    launch(NEVER, 1'b0, 1'b0, 1'b1);
    launch(WD, 1'b0, 1'b0, 1'b1);
    launch(30, 1'b1, 1'b0, 1'b1);
    launch(50, 1'b0, 1'b1, 1'b1);
    launch(1, 1'b0, 1'b0, 1'b1);
    launch(WD - 1, 1'b0, 1'b0, 1'b1);
    reset_mid_run();
    launch($urandom_range(1, WD), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      t = $urandom_range(1, WD + 20);
      h = 1'($urandom_range(0, 1));
      launch(t, h, !h && (t >= 10) && ($urandom_range(0, 1) == 1), 1'b1);
    end

    repeat (5) @(posedge clk);
    check("load_q_drained", load_q.size(), 0);
    check("run_q_drained", run_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
